// File: rtl/nn_sched_pkg.sv
// Shared types and constants for the RNN scheduler.
// NN_SCHED_SKIP_H0_EN: step-1 hidden rows skip the all-zero W*h0 terms.
package nn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE_H, S_WAIT_H, S_ISSUE_Y, S_DRAIN, S_OUT
  } state_t;

  localparam logic KIND_HIDDEN = 1'b0;
  localparam logic KIND_OUTPUT = 1'b1;

  localparam logic [1:0] MAT_U = 2'd0;
  localparam logic [1:0] MAT_W = 2'd1;
  localparam logic [1:0] MAT_V = 2'd2;

  localparam int DIM     = 3;
  localparam int STEPS   = 3;
  localparam int RESULTS = 18;

  localparam int OPS_PER_HROW_FULL = 2 * DIM;
`ifdef NN_SCHED_SKIP_H0_EN
  localparam int OPS_PER_HROW = DIM;
`else
  localparam int OPS_PER_HROW = 2 * DIM;
`endif

endpackage

// File: rtl/nn_sched_operand_rf.sv
// Operand storage for U, W, V and x (9 words each) with the load-index counter.
// All four streams are written in parallel; two combinational read ports.
module nn_sched_operand_rf
  import nn_sched_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_u,
  input  logic [DW-1:0] wr_w,
  input  logic [DW-1:0] wr_v,
  input  logic [DW-1:0] wr_x,
  output logic          load_last,
  input  logic [1:0]    rd_mat,
  input  logic [3:0]    rd_a_idx,
  input  logic [3:0]    rd_x_idx,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_x
);

  localparam int MW = DIM * DIM;

  logic [DW-1:0] mem [4*MW];
  logic [3:0]    load_idx;
  logic [5:0]    addr_a;
  logic [5:0]    addr_x;

  assign load_last = (load_idx == 4'(MW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     load_idx <= '0;
    else if (wr_en) load_idx <= load_last ? 4'd0 : load_idx + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{2'b00, load_idx}]               <= wr_u;
      mem[6'(MW)     + {2'b00, load_idx}]  <= wr_w;
      mem[6'(2 * MW) + {2'b00, load_idx}]  <= wr_v;
      mem[6'(3 * MW) + {2'b00, load_idx}]  <= wr_x;
    end
  end

  assign addr_a = {4'b0000, rd_mat} * 6'(MW) + {2'b00, rd_a_idx};
  assign addr_x = 6'(3 * MW) + {2'b00, rd_x_idx};
  assign rd_a   = mem[addr_a];
  assign rd_x   = mem[addr_x];

endmodule

// File: rtl/nn_rnn_scheduler.sv
// Sequences operand pairs of a 3-step RNN onto the shared FP MAC datapath.
// NN_SCHED_SKIP_H0_EN (via nn_sched_pkg) shortens step-1 hidden rows to 3 ops.
//
// state    | meaning
// IDLE     | waiting for first load word
// LOAD     | capturing 9 words per stream
// ISSUE_H  | issuing U*x_t and W*h_{t-1} rows
// WAIT_H   | waiting for h_t[0..2] to come back
// ISSUE_Y  | issuing V*h_t rows
// DRAIN    | waiting for the remaining results
// OUT      | streaming y1..y3 on out
module nn_rnn_scheduler
  import nn_sched_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid_u,
  input  logic                         in_valid_w,
  input  logic                         in_valid_v,
  input  logic                         in_valid_x,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] weight_u,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] weight_w,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] weight_v,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] data_x,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0] op_a,
  output logic [SIG_WIDTH+EXP_WIDTH:0] op_b,
  output logic                         op_clr,
  output logic                         op_last,
  output logic                         op_kind,
  input  logic                         res_valid,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] res_data,
  output logic                         out_valid,
  output logic [SIG_WIDTH+EXP_WIDTH:0] out
);

  localparam int DW = SIG_WIDTH + EXP_WIDTH + 1;

  state_t        state, state_nx;
  logic [1:0]    t, t_nx, row, row_nx, res_st, res_st_nx, col, rd_mat;
  logic [2:0]    term, term_nx, res_ph, res_ph_nx, h_last_term;
  logic [4:0]    res_cnt, res_cnt_nx, last_cnt, last_cnt_nx, h_need;
  logic [3:0]    out_cnt, out_cnt_nx, rd_a_idx, rd_x_idx;
  logic [DW-1:0] h [DIM];
  logic [DW-1:0] h_prev [DIM];
  logic [DW-1:0] y [DIM*STEPS];
  logic [DW-1:0] rd_a, rd_x, b_sel, op_a_nx, op_b_nx, out_nx;
  logic          wr_en, load_last, start_issue, issue_h, issue_y, adv, term_last;
  logic          res_acc, op_xfer, snap;
  logic          op_valid_nx, op_clr_nx, op_last_nx, op_kind_nx, out_valid_nx;

  // in_valid_w/v/x travel with in_valid_u, which alone qualifies the load.
  assign wr_en       = ((state == S_IDLE) || (state == S_LOAD)) && in_valid_u;
  assign start_issue = (state == S_LOAD) && wr_en && load_last;
  assign issue_h     = (state == S_ISSUE_H) || start_issue;
  assign issue_y     = (state == S_ISSUE_Y);
  assign op_xfer     = op_valid && op_ready;
  assign adv         = (issue_h || issue_y) && (!op_valid || op_ready);
  assign h_last_term = (t == 2'd1) ? 3'(OPS_PER_HROW - 1) : 3'(OPS_PER_HROW_FULL - 1);
  assign term_last   = issue_y ? (term == 3'd2) : (term == h_last_term);
  assign res_acc     = res_valid && (res_cnt != last_cnt);
  assign h_need      = {3'b000, t} * 5'd6 - 5'd3;

  nn_sched_operand_rf #(.DW(DW)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_u      (weight_u),
    .wr_w      (weight_w),
    .wr_v      (weight_v),
    .wr_x      (data_x),
    .load_last (load_last),
    .rd_mat    (rd_mat),
    .rd_a_idx  (rd_a_idx),
    .rd_x_idx  (rd_x_idx),
    .rd_a      (rd_a),
    .rd_x      (rd_x)
  );

  always_comb begin
    col      = (issue_h && term >= 3'd3) ? 2'(term - 3'd3) : term[1:0];
    rd_a_idx = {2'b00, row} * 4'd3 + {2'b00, col};
    rd_x_idx = ({2'b00, t} - 4'd1) * 4'd3 + {2'b00, col};
    rd_mat   = MAT_U;
    b_sel    = rd_x;
    if (issue_y) begin
      rd_mat = MAT_V;
      b_sel  = h[col];
    end else if (term >= 3'd3) begin
      rd_mat = MAT_W;
      b_sel  = h_prev[col];
    end
  end

  always_comb begin
    state_nx     = state;
    t_nx         = t;
    row_nx       = row;
    term_nx      = term;
    res_cnt_nx   = res_cnt;
    res_ph_nx    = res_ph;
    res_st_nx    = res_st;
    last_cnt_nx  = last_cnt;
    out_cnt_nx   = out_cnt;
    op_valid_nx  = op_valid;
    op_a_nx      = op_a;
    op_b_nx      = op_b;
    op_clr_nx    = op_clr;
    op_last_nx   = op_last;
    op_kind_nx   = op_kind;
    out_valid_nx = out_valid;
    out_nx       = out;
    snap         = 1'b0;

    if (res_acc) begin
      res_cnt_nx = res_cnt + 5'd1;
      res_ph_nx  = (res_ph == 3'd5) ? 3'd0 : res_ph + 3'd1;
      res_st_nx  = (res_ph == 3'd5) ? res_st + 2'd1 : res_st;
    end
    if (op_xfer && op_last) last_cnt_nx = last_cnt + 5'd1;

    case (state)
      S_IDLE:   if (in_valid_u) begin state_nx = S_LOAD; t_nx = 2'd1; end
      S_LOAD:   if (start_issue) state_nx = S_ISSUE_H;
      S_WAIT_H: if (res_cnt >= h_need) state_nx = S_ISSUE_Y;
      S_DRAIN: begin
        if (res_acc && res_cnt == 5'(RESULTS - 1)) begin
          state_nx     = S_OUT;
          out_valid_nx = 1'b1;
          out_nx       = y[0];
        end
      end
      S_OUT: begin
        if (out_cnt == 4'(DIM * STEPS - 1)) begin
          state_nx     = S_IDLE;
          out_valid_nx = 1'b0;
          out_nx       = '0;
          t_nx         = '0;
          res_cnt_nx   = '0;
          res_ph_nx    = '0;
          res_st_nx    = '0;
          last_cnt_nx  = '0;
          out_cnt_nx   = '0;
        end else begin
          out_cnt_nx = out_cnt + 4'd1;
          out_nx     = y[out_cnt + 4'd1];
        end
      end
      default: ;
    endcase

    // The op register reloads whenever it is empty or its pair transfers.
    if (adv) begin
      op_valid_nx = 1'b1;
      op_a_nx     = rd_a;
      op_b_nx     = b_sel;
      op_clr_nx   = (term == 3'd0);
      op_last_nx  = term_last;
      op_kind_nx  = (issue_y && term_last) ? KIND_OUTPUT : KIND_HIDDEN;
      if (!term_last) begin
        term_nx = term + 3'd1;
      end else begin
        term_nx = '0;
        if (row != 2'(DIM - 1)) begin
          row_nx = row + 2'd1;
        end else begin
          row_nx = '0;
          if (issue_h)                state_nx = S_WAIT_H;
          else if (t == 2'(STEPS))    state_nx = S_DRAIN;
          else begin
            state_nx = S_ISSUE_H;
            t_nx     = t + 2'd1;
            snap     = 1'b1;
          end
        end
      end
    end else if (op_xfer) begin
      op_valid_nx = 1'b0;
      op_a_nx     = '0;
      op_b_nx     = '0;
      op_clr_nx   = 1'b0;
      op_last_nx  = 1'b0;
      op_kind_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      t         <= '0;
      row       <= '0;
      term      <= '0;
      res_cnt   <= '0;
      res_ph    <= '0;
      res_st    <= '0;
      last_cnt  <= '0;
      out_cnt   <= '0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_clr    <= 1'b0;
      op_last   <= 1'b0;
      op_kind   <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      state     <= state_nx;
      t         <= t_nx;
      row       <= row_nx;
      term      <= term_nx;
      res_cnt   <= res_cnt_nx;
      res_ph    <= res_ph_nx;
      res_st    <= res_st_nx;
      last_cnt  <= last_cnt_nx;
      out_cnt   <= out_cnt_nx;
      op_valid  <= op_valid_nx;
      op_a      <= op_a_nx;
      op_b      <= op_b_nx;
      op_clr    <= op_clr_nx;
      op_last   <= op_last_nx;
      op_kind   <= op_kind_nx;
      out_valid <= out_valid_nx;
      out       <= out_nx;
    end
  end

  // h_prev snapshots h_{t-1} so early h_{t} results cannot corrupt W*h operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) begin
        h[i]      <= '0;
        h_prev[i] <= '0;
      end
      for (int i = 0; i < DIM * STEPS; i++) y[i] <= '0;
    end else begin
      if (start_issue) begin
        for (int i = 0; i < DIM; i++) h_prev[i] <= '0;
      end else if (snap) begin
        for (int i = 0; i < DIM; i++) h_prev[i] <= h[i];
      end
      if (res_acc) begin
        if (res_ph < 3'd3) h[res_ph[1:0]] <= res_data;
        else y[{2'b00, res_st} * 4'd3 + {1'b0, res_ph} - 4'd3] <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_nn_rnn_scheduler.sv
// Randomized self-checking bench for nn_rnn_scheduler against a loop-level RNN
// schedule model; honours NN_SCHED_SKIP_H0_EN when defined.
module tb_nn_rnn_scheduler;

  localparam int SIG_WIDTH = 23;
  localparam int EXP_WIDTH = 8;
  localparam int DW        = SIG_WIDTH + EXP_WIDTH + 1;
`ifdef NN_SCHED_SKIP_H0_EN
  localparam bit SKIP_H0 = 1'b1;
`else
  localparam bit SKIP_H0 = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          clr;
    logic          last;
    logic          kind;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_u, in_valid_w, in_valid_v, in_valid_x;
  logic [DW-1:0] weight_u, weight_w, weight_v, data_x;
  logic          op_valid, op_ready, op_clr, op_last, op_kind;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_rnn_scheduler #(.SIG_WIDTH(SIG_WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_u (in_valid_u),
    .in_valid_w (in_valid_w),
    .in_valid_v (in_valid_v),
    .in_valid_x (in_valid_x),
    .weight_u   (weight_u),
    .weight_w   (weight_w),
    .weight_v   (weight_v),
    .data_x     (data_x),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_clr     (op_clr),
    .op_last    (op_last),
    .op_kind    (op_kind),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .out_valid  (out_valid),
    .out        (out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid_u = 0; in_valid_w = 0; in_valid_v = 0; in_valid_x = 0;
    weight_u = '0; weight_w = '0; weight_v = '0; data_x = '0;
    op_ready = 0; res_valid = 0; res_data = '0;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_case(input bit ident, input int ready_pct, input bit stall4,
                          input bit withhold, input bit garbage, input int abort_at);
    logic [DW-1:0] mu [9];
    logic [DW-1:0] mw [9];
    logic [DW-1:0] mv [9];
    logic [DW-1:0] mx [9];
    logic [DW-1:0] resv [18];
    op_t           exp_ops [$];
    logic [DW-1:0] exp_y [$];
    op_t           o;
    int n_xfer, lasts, res_sent, out_seen, stall_cnt, wait_cnt, cyc, n_hid1, nterm;
    bit done, avail;

    for (int k = 0; k < 9; k++) begin
      if (ident) begin
        mu[k] = (k % 4 == 0) ? 32'h3F80_0000 : 32'h0;
        mw[k] = mu[k];
        mv[k] = mu[k];
        mx[k] = 32'h4000_0000;
      end else begin
        mu[k] = $urandom; mw[k] = $urandom; mv[k] = $urandom; mx[k] = $urandom;
      end
    end
    for (int k = 0; k < 18; k++) resv[k] = ident ? 32'h3F80_0000 + k : $urandom;

    // Reference schedule: per step, hidden rows then output rows; result k of
    // step t sits at resv[(t-1)*6 + k], hidden first.
    for (int t = 1; t <= 3; t++) begin
      nterm = (SKIP_H0 && t == 1) ? 3 : 6;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < nterm; j++) begin
          o.a    = (j < 3) ? mu[i*3+j] : mw[i*3+j-3];
          o.b    = (j < 3) ? mx[(t-1)*3+j] : ((t == 1) ? '0 : resv[(t-2)*6 + j-3]);
          o.clr  = (j == 0);
          o.last = (j == nterm - 1);
          o.kind = 1'b0;
          exp_ops.push_back(o);
        end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          o.a    = mv[i*3+j];
          o.b    = resv[(t-1)*6 + j];
          o.clr  = (j == 0);
          o.last = (j == 2);
          o.kind = (j == 2);
          exp_ops.push_back(o);
        end
      for (int i = 0; i < 3; i++) exp_y.push_back(resv[(t-1)*6 + 3 + i]);
    end
    n_hid1 = SKIP_H0 ? 9 : 18;

    for (int k = 0; k < 9; k++) begin
      in_valid_u = 1; in_valid_w = 1; in_valid_v = 1; in_valid_x = 1;
      weight_u = mu[k]; weight_w = mw[k]; weight_v = mv[k]; data_x = mx[k];
      op_ready = 1; res_valid = 0;
      @(negedge clk);
    end

    n_xfer = 0; lasts = 0; res_sent = 0; out_seen = 0;
    stall_cnt = 0; wait_cnt = 0; cyc = 0; done = 0;
    while (!done && cyc < 4000) begin
      if (garbage && n_xfer < exp_ops.size()) begin
        avail = $urandom_range(1);
        in_valid_u = avail; in_valid_w = avail; in_valid_v = avail; in_valid_x = 1;
        weight_u = $urandom; weight_w = $urandom; weight_v = $urandom; data_x = $urandom;
      end else begin
        in_valid_u = 0; in_valid_w = 0; in_valid_v = 0; in_valid_x = 0;
      end
      if (cyc == 0) check("first_op_valid", op_valid, 1'b1);

      if (out_valid) begin
        if (out_seen < 9) check("out_y", out_data, exp_y[out_seen]);
        else check("out_len", out_seen, 8);
        out_seen++;
      end else if (out_seen > 0) begin
        check("out_len", out_seen, 9);
        check("out_zero", out_data, '0);
        check("op_count", n_xfer, exp_ops.size());
        done = 1;
      end

      if (stall4 && op_valid && n_xfer == 3 && stall_cnt < 5) begin
        op_ready = 0;
        stall_cnt++;
        check("stall_hold", {op_a, op_b, op_clr, op_last, op_kind}, exp_ops[3]);
      end else begin
        op_ready = ($urandom_range(99) < ready_pct);
      end

      if (withhold && n_xfer >= n_hid1 && wait_cnt < 12) begin
        check("dep_gap", op_valid, 1'b0);
        wait_cnt++;
      end

      avail = !(withhold && wait_cnt < 12) && (res_sent < lasts) && ($urandom_range(2) != 0);
      res_valid = avail;
      res_data  = avail ? resv[res_sent] : $urandom;
      if (avail) res_sent++;

      if (op_valid && op_ready) begin
        if (n_xfer < exp_ops.size())
          check("op", {op_a, op_b, op_clr, op_last, op_kind}, exp_ops[n_xfer]);
        else
          check("op_extra", n_xfer, exp_ops.size());
        n_xfer++;
        if (op_last) lasts++;
      end

      if (abort_at > 0 && n_xfer >= abort_at) begin
        #2 rst_n = 0;
        #1;
        check("abort_op_valid", op_valid, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        return;
      end

      @(negedge clk);
      cyc++;
    end
    if (!done) check("timeout", done, 1'b1);
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #1;
    check("reset_flags", {op_valid, op_clr, op_last, op_kind, out_valid}, 5'b0);
    check("reset_data", {op_a, op_b, out_data}, 96'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      res_valid = 1;
      res_data  = $urandom;
      @(negedge clk);
      check("idle_spurious", {op_valid, out_valid}, 2'b0);
    end
    res_valid = 0;

    run_case(1, 100, 1, 1, 0, 0);
    run_case(0, 100, 0, 0, 0, 5);
    run_case(0, 100, 0, 0, 0, 0);
    run_case(0, 60,  0, 0, 1, 0);
    run_case(0, 40,  1, 0, 0, 0);
    run_case(1, 75,  0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
